// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - mode type and mode constants for the universal register
package univ_reg_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_SHL  = 3'd1;
    localparam mode_t MODE_SHR  = 3'd2;
    localparam mode_t MODE_LOAD = 3'd3;
    localparam mode_t MODE_UP   = 3'd4;
    localparam mode_t MODE_DOWN = 3'd5;
    localparam mode_t MODE_ROL  = 3'd6;
    localparam mode_t MODE_ROR  = 3'd7;

endpackage

// File: rtl/univ_reg_slice.sv
// rtl/univ_reg_slice.sv - one register bit: next-state mux, sync-reset flop with clock enable
module univ_reg_slice
    import univ_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] mode,
    input  logic       ld_in,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       rol_in,
    input  logic       ror_in,
    input  logic       up_in,
    input  logic       dn_in,
    output logic       q,
    output logic       qdash
);

    // Power-up value matches the reset value so Q is defined before the first reset.
    logic q_r = RST_BIT;
    logic q_nxt;

    // Select this bit's next value from the neighbour/serial/count candidates.
    always_comb begin
        q_nxt = q_r;
        case (mode_t'(mode))
            MODE_HOLD: q_nxt = q_r;
            MODE_SHL:  q_nxt = shl_in;
            MODE_SHR:  q_nxt = shr_in;
            MODE_LOAD: q_nxt = ld_in;
            MODE_UP:   q_nxt = up_in;
            MODE_DOWN: q_nxt = dn_in;
            MODE_ROL:  q_nxt = rol_in;
            MODE_ROR:  q_nxt = ror_in;
            default:   q_nxt = q_r;
        endcase
    end

    // Reset wins over enable; enable low holds regardless of mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_BIT;
        end else if (ce) begin
            q_r <= q_nxt;
        end
    end

    assign q     = q_r;
    assign qdash = ~q_r;

endmodule

// File: rtl/univ_reg.sv
// rtl/univ_reg.sv - universal shift/rotate/load/count register; UNIV_REG_COUNT_EN enables UP/DOWN and TC
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qdash,
    output logic             TC
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] up_v;
    logic [WIDTH-1:0] dn_v;

    assign shl_v = {q[WIDTH-2:0], SIL};
    assign shr_v = {SIR, q[WIDTH-1:1]};
    assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
    assign ror_v = {q[0], q[WIDTH-1:1]};

`ifdef UNIV_REG_COUNT_EN
    assign up_v = q + WIDTH'(1);
    assign dn_v = q - WIDTH'(1);
    // Terminal count is combinational so a cascaded upper stage sees it in the same cycle.
    assign TC   = CE & (((mode_t'(MODE) == MODE_UP) & (&q)) |
                        ((mode_t'(MODE) == MODE_DOWN) & (q == '0)));
`else
    // Without the counter, UP/DOWN feed each bit back to itself and behave as HOLD.
    assign up_v = q;
    assign dn_v = q;
    assign TC   = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        univ_reg_slice #(
            .RST_BIT (RESET_VAL[i])
        ) u_slice (
            .clk    (CLK),
            .rst    (RST),
            .ce     (CE),
            .mode   (MODE),
            .ld_in  (D[i]),
            .shl_in (shl_v[i]),
            .shr_in (shr_v[i]),
            .rol_in (rol_v[i]),
            .ror_in (ror_v[i]),
            .up_in  (up_v[i]),
            .dn_in  (dn_v[i]),
            .q      (q[i]),
            .qdash  (Qdash[i])
        );
    end

    assign Q = q;

endmodule

// File: tb/tb_univ_reg.sv
// tb/tb_univ_reg.sv - self-checking bench for univ_reg with a reference model and a two-stage cascade
module tb_univ_reg;

`ifdef UNIV_REG_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CE = 1'b0;
    logic [2:0] MODE = 3'd0;
    logic [7:0] D = 8'h00;
    logic       SIL = 1'b0;
    logic       SIR = 1'b0;
    logic [7:0] Q;
    logic [7:0] Qdash;
    logic       TC;

    logic       c_rst = 1'b0;
    logic [2:0] c_mode = 3'd0;
    logic [3:0] c_dlo = 4'h0;
    logic [3:0] c_dhi = 4'h0;
    logic       c_link = 1'b0;
    logic       c_ce_hi;
    logic [3:0] qlo, qhi, qdlo, qdhi;
    logic       tc_lo, tc_hi;

    int total = 0;
    int bad = 0;
    logic [7:0] mq;
    int         cm;

    always #5 CLK = ~CLK;

    univ_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .D(D),
        .SIL(SIL), .SIR(SIR), .Q(Q), .Qdash(Qdash), .TC(TC)
    );

    assign c_ce_hi = c_link ? tc_lo : 1'b1;

    univ_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_lo (
        .CLK(CLK), .RST(c_rst), .CE(1'b1), .MODE(c_mode), .D(c_dlo),
        .SIL(1'b0), .SIR(1'b0), .Q(qlo), .Qdash(qdlo), .TC(tc_lo)
    );

    univ_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_hi (
        .CLK(CLK), .RST(c_rst), .CE(c_ce_hi), .MODE(c_mode), .D(c_dhi),
        .SIL(1'b0), .SIR(1'b0), .Q(qhi), .Qdash(qdhi), .TC(tc_hi)
    );

    function automatic logic [7:0] model_next(logic [7:0] q, logic rst, logic ce, logic [2:0] mode,
                                              logic [7:0] d, logic sil, logic sir);
        int v;
        v = int'(q);
        if (rst) return 8'hA5;
        if (!ce) return q;
        case (mode)
            3'd1: v = (v * 2 + int'(sil)) % 256;
            3'd2: v = v / 2 + int'(sir) * 128;
            3'd3: v = int'(d);
            3'd4: v = CNT_EN ? (v + 1) % 256 : v;
            3'd5: v = CNT_EN ? (v + 255) % 256 : v;
            3'd6: v = (v * 2) % 256 + v / 128;
            3'd7: v = v / 2 + (v % 2) * 128;
            default: v = v;
        endcase
        return v[7:0];
    endfunction

    function automatic logic model_tc(logic [7:0] q, logic ce, logic [2:0] mode);
        return CNT_EN && ce && ((mode == 3'd4 && q == 8'd255) || (mode == 3'd5 && q == 8'd0));
    endfunction

    task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ce, input logic [2:0] mode,
                        input logic [7:0] d, input logic sil, input logic sir, input string tag);
        RST = rst; CE = ce; MODE = mode; D = d; SIL = sil; SIR = sir;
        #1;
        chk({7'd0, TC}, {7'd0, model_tc(mq, ce, mode)}, {tag, "_tc"});
        @(posedge CLK);
        mq = model_next(mq, rst, ce, mode, d, sil, sir);
        #1;
        chk(Q, mq, {tag, "_q"});
        chk(Qdash, ~mq, {tag, "_qdash"});
    endtask

    task automatic cstep(input logic rst, input logic link, input logic [2:0] mode,
                         input logic [7:0] d, input string tag);
        c_rst = rst; c_link = link; c_mode = mode; c_dlo = d[3:0]; c_dhi = d[7:4];
        @(posedge CLK);
        if (rst) cm = 0;
        else if (mode == 3'd3) cm = int'(d);
        else if (mode == 3'd4) cm = CNT_EN ? (cm + 1) % 256 : cm;
        #1;
        chk({qhi, qlo}, cm[7:0], {tag, "_q"});
        chk({qdhi, qdlo}, ~cm[7:0], {tag, "_qdash"});
    endtask

    initial begin
        mq = 8'hA5;
        cm = 0;
        #1;
        chk(Q, 8'hA5, "powerup_q");
        chk(Qdash, 8'h5A, "powerup_qdash");

        step(1, 1, 3'd0, 8'h00, 0, 0, "reset");
        chk(Q, 8'hA5, "reset_abs");
        step(1, 1, 3'd3, 8'hFF, 0, 0, "reset_over_load");
        chk(Q, 8'hA5, "reset_over_load_abs");

        step(0, 1, 3'd3, 8'h3C, 0, 0, "load3c");
        chk(Q, 8'h3C, "load3c_abs");
        for (int i = 0; i < 5; i++) step(0, 0, 3'd4, 8'h00, 1, 1, "ce0_hold");
        chk(Q, 8'h3C, "ce0_hold_abs");

        step(0, 1, 3'd3, 8'h81, 0, 0, "ld81");
        step(0, 1, 3'd1, 8'h00, 0, 0, "shl");
        chk(Q, 8'h02, "shl_abs");
        step(0, 1, 3'd3, 8'h81, 0, 0, "ld81");
        step(0, 1, 3'd2, 8'h00, 0, 1, "shr");
        chk(Q, 8'hC0, "shr_abs");
        step(0, 1, 3'd3, 8'h81, 0, 0, "ld81");
        step(0, 1, 3'd6, 8'h00, 0, 0, "rol");
        chk(Q, 8'h03, "rol_abs");
        step(0, 1, 3'd3, 8'h81, 0, 0, "ld81");
        step(0, 1, 3'd7, 8'h00, 0, 0, "ror");
        chk(Q, 8'hC0, "ror_abs");

        step(0, 1, 3'd3, 8'hFE, 0, 0, "ldfe");
        step(0, 1, 3'd4, 8'h00, 0, 0, "up_fe");
        step(0, 1, 3'd4, 8'h00, 0, 0, "up_wrap");
        step(0, 1, 3'd3, 8'h01, 0, 0, "ld01");
        step(0, 1, 3'd5, 8'h00, 0, 0, "dn_01");
        step(0, 1, 3'd5, 8'h00, 0, 0, "dn_wrap");
        step(0, 1, 3'd3, 8'h10, 0, 0, "ld10");
        for (int i = 0; i < 3; i++) step(0, 1, 3'd4, 8'h00, 0, 0, "up_from10");
        step(1, 1, 3'd4, 8'h00, 0, 0, "reset_mid_count");
        chk(Q, 8'hA5, "reset_mid_count_abs");

        for (int i = 0; i < 400; i++) begin
            logic [7:0] rd;
            rd = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rd = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 rd, 1'($urandom), 1'($urandom), "rand");
        end

        cstep(1, 0, 3'd0, 8'h00, "c_reset");
        cstep(0, 0, 3'd3, 8'h0F, "c_ld0f");
        cstep(0, 1, 3'd4, 8'h00, "c_carry");
        cstep(1, 0, 3'd0, 8'h00, "c_reset2");
        for (int i = 0; i < 256; i++) cstep(0, 1, 3'd4, 8'h00, "c_count");
        chk({qhi, qlo}, 8'h00, "c_count256_abs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
